// File: rtl/module_display_scan_ctrl.sv
// Digit scan sequencer for the 4:1 nibble mux + seven-segment path, with frame-aligned
// double-buffered display data. Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module module_display_scan_ctrl #(
  parameter int unsigned  N_DIGITS    = 4,
  parameter int unsigned  REFRESH_CNT = 25000,
  parameter int unsigned  BLANK_CNT   = 2,
  localparam int unsigned SEL_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  localparam int unsigned DATA_W      = 4 * N_DIGITS
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              load_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic [3:0]        digit_o,
  output logic [7:0]        an_o,
  output logic              frame_o
);

  localparam int unsigned CNT_MAX = (REFRESH_CNT > BLANK_CNT) ? REFRESH_CNT : BLANK_CNT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] REF_LAST   = CNT_W'(REFRESH_CNT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CNT > 0) ? (BLANK_CNT - 1) : 32'd0);
  localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(N_DIGITS - 1);
  localparam bit               HAS_BLANK  = (BLANK_CNT > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic                frame_q, frame_d;
  logic [7:0]          an_q, an_d;

  logic                frame_start;
  logic [SEL_W-1:0]    idx_next;
  logic                lead_zero;

  // State register and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      frame_q  <= 1'b0;
      an_q     <= 8'hFF;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      frame_q  <= frame_d;
      an_q     <= an_d;
    end
  end

  // Next-state, scan counters, frame-aligned buffer swap and anode decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    pend_d      = pend_q;
    pend_v_d    = pend_v_q;
    frame_start = 1'b0;
    lead_zero   = 1'b0;
    an_d        = 8'hFF;
    idx_next    = (idx_q == IDX_LAST) ? '0 : (idx_q + SEL_W'(1));

    if (load_i) begin
      pend_d   = data_i;
      pend_v_d = 1'b1;
    end

    if (!en_i) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_SHOW;
          idx_d       = '0;
          cnt_d       = '0;
          frame_start = 1'b1;
        end
        ST_SHOW: begin
          if (cnt_q == REF_LAST) begin
            cnt_d = '0;
            if (HAS_BLANK) begin
              state_d = ST_BLANK;
            end else begin
              idx_d       = idx_next;
              frame_start = (idx_q == IDX_LAST);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d       = '0;
            state_d     = ST_SHOW;
            idx_d       = idx_next;
            frame_start = (idx_q == IDX_LAST);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // A load landing on the frame start bypasses the pending buffer
    if (frame_start) begin
      if (load_i) begin
        data_d = data_i;
      end else if (pend_v_q) begin
        data_d = pend_q;
      end
      pend_v_d = 1'b0;
    end

`ifdef LEADING_ZERO_BLANK_EN
    lead_zero = (idx_d != '0) && ((data_d >> {idx_d, 2'b00}) == '0);
`endif

    if (state_d == ST_SHOW && !lead_zero) begin
      an_d = ~(8'h01 << idx_d);
    end
  end

  assign frame_d = frame_start;
  assign sel_o   = idx_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;
  assign digit_o = 4'(data_q >> {idx_q, 2'b00});

endmodule
